// File: rtl/rtc_bus_pkg.sv
// Shared types for the RTC bus master: FSM states, per-state strobe patterns
// and the captured transaction payload.
package rtc_bus_pkg;

  localparam int unsigned DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_GAP     = 3'd2,
    ST_DATA    = 3'd3,
    ST_RECOVER = 3'd4
  } state_e;

  typedef struct packed {
    logic cs_n;
    logic ad_n;
    logic rd_n;
    logic wr_n;
    logic dq_oe;
  } strobe_t;

  localparam strobe_t STB_IDLE    = '{cs_n: 1'b1, ad_n: 1'b1, rd_n: 1'b1, wr_n: 1'b1, dq_oe: 1'b0};
  localparam strobe_t STB_ADDR    = '{cs_n: 1'b0, ad_n: 1'b0, rd_n: 1'b1, wr_n: 1'b0, dq_oe: 1'b1};
  localparam strobe_t STB_GAP     = '{cs_n: 1'b0, ad_n: 1'b1, rd_n: 1'b1, wr_n: 1'b1, dq_oe: 1'b0};
  localparam strobe_t STB_DATA_WR = '{cs_n: 1'b0, ad_n: 1'b1, rd_n: 1'b1, wr_n: 1'b0, dq_oe: 1'b1};
  localparam strobe_t STB_DATA_RD = '{cs_n: 1'b0, ad_n: 1'b1, rd_n: 1'b0, wr_n: 1'b1, dq_oe: 1'b0};
  localparam strobe_t STB_RECOVER = STB_IDLE;

  // One bus transaction; burst marks refresh reads that never reach the host.
  typedef struct packed {
    logic              burst;
    logic              wr;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } xact_t;

  function automatic strobe_t strobe_for(input state_e st, input logic wr);
    strobe_t s;
    s = STB_IDLE;
    case (st)
      ST_ADDR:    s = STB_ADDR;
      ST_GAP:     s = STB_GAP;
      ST_DATA:    s = wr ? STB_DATA_WR : STB_DATA_RD;
      ST_RECOVER: s = STB_RECOVER;
      default:    s = STB_IDLE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/rtc_bus_master_if.sv
// Host request/response handshake plus the multiplexed RTC bus pins.
interface rtc_bus_master_if;
  import rtc_bus_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [DATA_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              cs_n;
  logic              ad_n;
  logic              rd_n;
  logic              wr_n;
  logic [DATA_W-1:0] dq_o;
  logic              dq_oe;
  logic [DATA_W-1:0] dq_i;

  modport master (
    input  req_valid, req_wr, req_addr, req_wdata, dq_i,
    output req_ready, rsp_valid, rsp_rdata, cs_n, ad_n, rd_n, wr_n, dq_o, dq_oe
  );

  modport slave (
    output req_valid, req_wr, req_addr, req_wdata, dq_i,
    input  req_ready, rsp_valid, rsp_rdata, cs_n, ad_n, rd_n, wr_n, dq_o, dq_oe
  );

endinterface

// File: rtl/rtc_phase_counter.sv
// Modulo-LEN cycle counter; done_c flags the last cycle of each LEN-cycle period.
module rtc_phase_counter #(
  parameter int unsigned LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  output logic done_c
);

  localparam int unsigned CW = (LEN > 1) ? $clog2(LEN) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign done_c = en_i && (cnt_q == CW'(LEN - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = done_c ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rtc_bus_master.sv
// Multiplexed-bus master for an RTC chip: serves host reads/writes and
// periodically refreshes a local shadow copy of N_REGS RTC registers.
module rtc_bus_master
  import rtc_bus_pkg::*;
#(
  parameter int unsigned PHASE_CYC   = 4,
  parameter int unsigned N_REGS      = 9,
  parameter logic [7:0]  REF_BASE    = 8'h21,
  parameter int unsigned REFRESH_DIV = 100000,
  localparam int unsigned IDX_W      = (N_REGS > 1) ? $clog2(N_REGS) : 1
) (
  input  logic               clk,
  input  logic               reset,
  rtc_bus_master_if.master   bus,
  input  logic               refresh_en,
  input  logic [IDX_W-1:0]   rf_addr,
  output logic [DATA_W-1:0]  rf_data,
  output logic               busy
);

  state_e            state_q, state_d;
  xact_t             xact_q, xact_d;
  strobe_t           stb_q, stb_d;
  logic [DATA_W-1:0] dq_q, dq_d;
  logic [DATA_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              pending_q, pending_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              rf_we;
  logic [DATA_W-1:0] rf_q [N_REGS];

  logic in_idle;
  logic ph_done;
  logic tick;

  assign in_idle = (state_q == ST_IDLE);

  rtc_phase_counter #(.LEN(PHASE_CYC)) u_phase (
    .clk    (clk),
    .rst    (reset),
    .en_i   (!in_idle),
    .clr_i  (in_idle),
    .done_c (ph_done)
  );

  rtc_phase_counter #(.LEN(REFRESH_DIV)) u_refresh_timer (
    .clk    (clk),
    .rst    (reset),
    .en_i   (1'b1),
    .clr_i  (1'b0),
    .done_c (tick)
  );

  // Next state, transaction capture, refresh bookkeeping and registered pin values.
  always_comb begin
    state_d     = state_q;
    xact_d      = xact_q;
    rd_d        = rd_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    pending_d   = pending_q;
    idx_d       = idx_q;
    rf_we       = 1'b0;

    // A tick only arms an idle refresh; ticks during a pending burst are dropped.
    if (!pending_q && tick && refresh_en) begin
      pending_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          xact_d.burst = 1'b0;
          xact_d.wr    = bus.req_wr;
          xact_d.addr  = bus.req_addr;
          xact_d.wdata = bus.req_wdata;
          state_d      = ST_ADDR;
        end else if (pending_q) begin
          xact_d.burst = 1'b1;
          xact_d.wr    = 1'b0;
          xact_d.addr  = REF_BASE + DATA_W'(idx_q);
          xact_d.wdata = '0;
          state_d      = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (ph_done) state_d = ST_GAP;
      end
      ST_GAP: begin
        if (ph_done) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (ph_done) begin
          state_d = ST_RECOVER;
          if (!xact_q.wr) rd_d = bus.dq_i;
        end
      end
      ST_RECOVER: begin
        if (ph_done) begin
          state_d = ST_IDLE;
          if (xact_q.burst) begin
            rf_we = 1'b1;
            if (idx_q == IDX_W'(N_REGS - 1)) begin
              idx_d     = '0;
              pending_d = 1'b0;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            rsp_valid_d = 1'b1;
            if (!xact_q.wr) rsp_rdata_d = rd_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Pins are registered from the next state so they line up with the state itself.
    stb_d = strobe_for(state_d, xact_d.wr);
    dq_d  = '0;
    case (state_d)
      ST_ADDR: dq_d = xact_d.addr;
      ST_DATA: if (xact_d.wr) dq_d = xact_d.wdata;
      default: dq_d = '0;
    endcase
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE) || pending_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      xact_q      <= '0;
      stb_q       <= STB_IDLE;
      dq_q        <= '0;
      rd_q        <= '0;
      rsp_rdata_q <= '0;
      rsp_valid_q <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      pending_q   <= 1'b0;
      idx_q       <= '0;
    end else begin
      state_q     <= state_d;
      xact_q      <= xact_d;
      stb_q       <= stb_d;
      dq_q        <= dq_d;
      rd_q        <= rd_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_valid_q <= rsp_valid_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      pending_q   <= pending_d;
      idx_q       <= idx_d;
    end
  end

  // Shadow register file filled by refresh bursts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < N_REGS; i++) begin
        rf_q[i] <= '0;
      end
    end else if (rf_we) begin
      rf_q[idx_q] <= rd_q;
    end
  end

  always_comb begin
    rf_data = '0;
    if (32'(rf_addr) < N_REGS) begin
      rf_data = rf_q[rf_addr];
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.cs_n      = stb_q.cs_n;
  assign bus.ad_n      = stb_q.ad_n;
  assign bus.rd_n      = stb_q.rd_n;
  assign bus.wr_n      = stb_q.wr_n;
  assign bus.dq_oe     = stb_q.dq_oe;
  assign bus.dq_o      = dq_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_rtc_bus_master.sv
// Scoreboard bench for rtc_bus_master: RTC bus slave model, host response and
// bus transaction queues, refresh burst and reset-abort scenarios.
module tb_rtc_bus_master;

  localparam int unsigned P    = 2;
  localparam int unsigned NR   = 3;
  localparam int unsigned DIV  = 100;
  localparam logic [7:0]  BASE = 8'h21;
  localparam int          XLEN = 4 * P + 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       refresh_en = 1'b0;
  logic [1:0] rf_addr = 2'd0;
  logic [7:0] rf_data;
  logic       busy;

  rtc_bus_master_if bif();

  rtc_bus_master #(
    .PHASE_CYC  (P),
    .N_REGS     (NR),
    .REF_BASE   (BASE),
    .REFRESH_DIV(DIV)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bif),
    .refresh_en(refresh_en),
    .rf_addr   (rf_addr),
    .rf_data   (rf_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int          cyc = 0;
  int          tmr_m = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference refresh timer: the tick falls in the cycle where tmr_m == DIV-1.
  always @(posedge clk or posedge reset) begin
    if (reset) tmr_m <= 0;
    else       tmr_m <= (tmr_m == int'(DIV) - 1) ? 0 : tmr_m + 1;
  end

  // RTC slave model.
  logic [7:0] mem [256];
  logic [7:0] cur_addr = 8'h00;

  assign bif.dq_i = (!bif.cs_n && !bif.rd_n) ? mem[cur_addr] : 8'h00;

  always @(negedge clk) begin
    if (!reset && !bif.cs_n) begin
      if (!bif.ad_n) cur_addr = bif.dq_o;
      else if (!bif.wr_n && bif.dq_oe) mem[cur_addr] = bif.dq_o;
    end
  end

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data;
  } bx_t;

  typedef struct {
    logic       wr;
    logic [7:0] rdata;
    int         cyc;
    logic       chk_hold;
  } rx_t;

  bx_t bus_q[$];
  rx_t rsp_q[$];

  logic       in_x = 1'b0;
  logic       saw_wr = 1'b0;
  logic [7:0] m_addr = 8'h00;
  logic [7:0] m_data = 8'h00;

  // Bus transaction monitor: one entry per completed cs_n window.
  always @(negedge clk) begin
    bx_t e;
    if (reset) begin
      in_x   = 1'b0;
      saw_wr = 1'b0;
    end else if (!bif.cs_n) begin
      if (!bif.ad_n) begin
        in_x   = 1'b1;
        saw_wr = 1'b0;
        m_addr = bif.dq_o;
      end else if (!bif.wr_n) begin
        saw_wr = 1'b1;
        m_data = bif.dq_o;
      end
    end else if (in_x) begin
      in_x = 1'b0;
      check("bus_expected", 32'(bus_q.size() != 0), 1);
      if (bus_q.size() != 0) begin
        e = bus_q.pop_front();
        check("bus_addr", 32'(m_addr), 32'(e.addr));
        check("bus_wr", 32'(saw_wr), 32'(e.wr));
        if (e.wr) check("bus_wdata", 32'(m_data), 32'(e.data));
      end
    end
  end

  // Host response monitor.
  always @(negedge clk) begin
    rx_t r;
    if (!reset && bif.rsp_valid) begin
      check("rsp_expected", 32'(rsp_q.size() != 0), 1);
      if (rsp_q.size() != 0) begin
        r = rsp_q.pop_front();
        check("rsp_cycle", 32'(cyc), 32'(r.cyc));
        if (!r.wr || r.chk_hold) check("rsp_rdata", 32'(bif.rsp_rdata), 32'(r.rdata));
      end
    end
  end

  task automatic check_bus(input int k, input logic wr, input logic [7:0] a, input logic [7:0] d);
    int         ph;
    logic [4:0] s;
    ph = (k - 1) / int'(P);
    s  = {bif.cs_n, bif.ad_n, bif.rd_n, bif.wr_n, bif.dq_oe};
    case (ph)
      0: begin
        check($sformatf("addr_strb[%0d]", k), 32'(s), 'h05);
        check($sformatf("addr_dq[%0d]", k), 32'(bif.dq_o), 32'(a));
      end
      1: check($sformatf("gap_strb[%0d]", k), 32'(s), 'h0E);
      2: begin
        if (wr) begin
          check($sformatf("dwr_strb[%0d]", k), 32'({s[4], s[3], s[1], s[0]}), 'h5);
          check($sformatf("dwr_dq[%0d]", k), 32'(bif.dq_o), 32'(d));
        end else begin
          check($sformatf("drd_strb[%0d]", k), 32'({s[4], s[3], s[2], s[0]}), 'h4);
        end
      end
      default: begin
        check($sformatf("idle_strb[%0d]", k), 32'(s), 'h1E);
        check($sformatf("idle_dq[%0d]", k), 32'(bif.dq_o), 0);
      end
    endcase
  endtask

  // One host transaction with per-cycle pin checks; returns at the IDLE cycle T+XLEN.
  task automatic run_host(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                          input logic [7:0] exp_rd, input logic chk_hold, input logic end_busy);
    int t;
    bit ok;
    @(posedge clk);
    #1;
    bif.req_valid = 1'b1;
    bif.req_wr    = wr;
    bif.req_addr  = addr;
    bif.req_wdata = wdata;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bif.req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("req_accept", 32'(ok), 1);
    t = cyc;
    if (ok) begin
      rsp_q.push_back('{wr: wr, rdata: exp_rd, cyc: t + XLEN, chk_hold: chk_hold});
      bus_q.push_back('{wr: wr, addr: addr, data: wdata});
    end
    @(posedge clk);
    #1;
    bif.req_valid = 1'b0;
    if (ok) begin
      for (int k = 1; k <= XLEN; k++) begin
        @(negedge clk);
        check_bus(k, wr, addr, wdata);
        check($sformatf("busy[%0d]", k), 32'(busy), (k < XLEN) ? 1 : 32'(end_busy));
      end
    end
  endtask

  task automatic check_rf(input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
    logic [7:0] e [4];
    e[0] = e0;
    e[1] = e1;
    e[2] = e2;
    e[3] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      rf_addr = 2'(i);
      #1;
      check($sformatf("rf[%0d]", i), 32'(rf_data), 32'(e[i]));
    end
  endtask

  task automatic push_burst();
    for (int i = 0; i < int'(NR); i++) begin
      bus_q.push_back('{wr: 1'b0, addr: BASE + 8'(i), data: 8'h00});
    end
  endtask

  initial begin
    bit ok;
    int t;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    bif.req_valid = 1'b0;
    bif.req_wr    = 1'b0;
    bif.req_addr  = 8'h00;
    bif.req_wdata = 8'h00;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_strb", 32'({bif.cs_n, bif.ad_n, bif.rd_n, bif.wr_n}), 'hF);
    check("rst_dq_oe", 32'(bif.dq_oe), 0);
    check("rst_dq_o", 32'(bif.dq_o), 0);
    check("rst_rsp_valid", 32'(bif.rsp_valid), 0);
    check("rst_rsp_rdata", 32'(bif.rsp_rdata), 0);
    check("rst_busy", 32'(busy), 0);
    check_rf(8'h00, 8'h00, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Host write, read, then a write that must leave rsp_rdata untouched.
    run_host(1'b1, 8'h22, 8'h10, 8'h00, 1'b1, 1'b0);
    check("mem_22", 32'(mem[8'h22]), 'h10);
    mem[8'h23] = 8'h59;
    run_host(1'b0, 8'h23, 8'h00, 8'h59, 1'b0, 1'b0);
    run_host(1'b1, 8'h30, 8'hC4, 8'h59, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    check("rdata_hold", 32'(bif.rsp_rdata), 'h59);

    // Auto-refresh burst.
    mem[8'h21] = 8'h11;
    mem[8'h22] = 8'h22;
    mem[8'h23] = 8'h33;
    push_burst();
    refresh_en = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (busy) begin
        ok = 1'b1;
        break;
      end
    end
    check("burst_start", 32'(ok), 1);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    check("burst_end", 32'(ok), 1);
    refresh_en = 1'b0;
    check("burst_bus_q", 32'(bus_q.size()), 0);
    check_rf(8'h11, 8'h22, 8'h33);

    // Host request in the tick cycle runs first; refresh_en drops mid-burst.
    mem[8'h22] = 8'h6B;
    mem[8'h23] = 8'h7C;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tmr_m == int'(DIV) - 2) begin
        ok = 1'b1;
        break;
      end
    end
    check("tick_align", 32'(ok), 1);
    refresh_en = 1'b1;
    run_host(1'b1, 8'h21, 8'h5A, 8'h00, 1'b0, 1'b1);
    push_burst();
    for (int k = XLEN + 1; k <= 4 * XLEN; k++) begin
      @(negedge clk);
      if (k == XLEN + 5) refresh_en = 1'b0;
      check($sformatf("busy_burst[%0d]", k), 32'(busy), (k < 4 * XLEN) ? 1 : 0);
    end
    repeat (3) @(negedge clk);
    check("arb_bus_q", 32'(bus_q.size()), 0);
    check_rf(8'h5A, 8'h6B, 8'h7C);

    // Reset during a DATA write phase aborts it.
    @(posedge clk);
    #1;
    bif.req_valid = 1'b1;
    bif.req_wr    = 1'b1;
    bif.req_addr  = 8'h40;
    bif.req_wdata = 8'hEE;
    @(negedge clk);
    check("abort_accept", 32'(bif.req_ready), 1);
    t = cyc;
    @(posedge clk);
    #1;
    bif.req_valid = 1'b0;
    while (cyc < t + 2 * int'(P) + 1) @(negedge clk);
    check("abort_pre_wr_n", 32'(bif.wr_n), 0);
    #2;
    reset = 1'b1;
    #1;
    check("abort_strb", 32'({bif.cs_n, bif.ad_n, bif.rd_n, bif.wr_n}), 'hF);
    check("abort_dq_oe", 32'(bif.dq_oe), 0);
    check("abort_dq_o", 32'(bif.dq_o), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_rsp_valid", 32'(bif.rsp_valid), 0);
    check("abort_rsp_rdata", 32'(bif.rsp_rdata), 0);
    check_rf(8'h00, 8'h00, 8'h00);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (15) @(negedge clk);
    check("post_rst_ready", 32'(bif.req_ready), 1);
    check("end_rsp_q", 32'(rsp_q.size()), 0);
    check("end_bus_q", 32'(bus_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rtc_bus_master.md
RTC_BUS_MASTER -- requirements
Module: rtc_bus_master

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameters (name, default, meaning), one per line:
- PHASE_CYC, 4: clock cycles per bus phase, minimum 1.
- N_REGS, 9: registers read per refresh burst.
- REF_BASE, 8'h21: first RTC address of the refresh burst.
- REFRESH_DIV, 100000: clock cycles between refresh ticks.
REQ-003 Ports (name, direction, width, meaning), one per line:
- clk, in, 1: clock.
- reset, in, 1: async active-high reset.
- req_valid, in, 1: host request valid.
- req_ready, out, 1: host request accepted when high with req_valid.
- req_wr, in, 1: 1 = write, 0 = read.
- req_addr, in, 8: RTC register address.
- req_wdata, in, 8: write data.
- rsp_valid, out, 1: one-cycle transaction-done pulse.
- rsp_rdata, out, 8: read data.
- refresh_en, in, 1: enables auto-refresh.
- rf_addr, in, clog2(N_REGS): register-file read index.
- rf_data, out, 8: register-file read data, combinational.
- busy, out, 1: high whenever state is not IDLE or a burst is unfinished.
- cs_n, ad_n, rd_n, wr_n, out, 1 each: active-low RTC bus strobes.
- dq_o, out, 8: multiplexed address/data out.
- dq_oe, out, 1: dq drive enable.
- dq_i, in, 8: multiplexed data in.

Function
REQ-004 FSM states SHALL be IDLE, ADDR, GAP, DATA, RECOVER; each non-IDLE state SHALL last exactly PHASE_CYC cycles.
REQ-005 req_ready SHALL be 1 only in IDLE; address, data and direction are captured at the accept edge, and the next cycle is ADDR.
REQ-006 ADDR: cs_n=0, ad_n=0, wr_n=0, rd_n=1, dq_oe=1, dq_o=address.
REQ-007 GAP: cs_n=0, ad_n=1, rd_n=1, wr_n=1, dq_oe=0.
REQ-008 DATA write: cs_n=0, ad_n=1, wr_n=0, dq_oe=1, dq_o=wdata.
REQ-009 DATA read: cs_n=0, ad_n=1, rd_n=0, dq_oe=0; dq_i is sampled on the last DATA cycle.
REQ-010 RECOVER and IDLE: all strobes 1, dq_oe=0, dq_o=0.
REQ-011 If accepted at cycle T, the block SHALL return to IDLE at T+4*PHASE_CYC+1, with rsp_valid=1 in that cycle only.
REQ-012 rsp_rdata SHALL update only on read completion and hold its value otherwise.
REQ-013 Refresh timer: free-running, wraps at REFRESH_DIV-1; a wrap with refresh_en=1 sets a single pending flag. Further ticks while pending are dropped.
REQ-014 Burst: while pending, read REF_BASE+i for i=0..N_REGS-1 in order; each result is written to rf[i]; pending clears after the last read.
REQ-015 Arbitration in IDLE: a host request SHALL win over a burst step; the burst resumes at the same index afterwards.
REQ-016 Burst reads SHALL NOT pulse rsp_valid.
REQ-017 rf_addr >= N_REGS SHALL return rf_data=0.
REQ-018 Deasserting refresh_en mid-burst SHALL let the burst complete.
REQ-019 The address arithmetic REF_BASE+i SHALL be 8-bit and wrap modulo 256.

Reset
REQ-020 On reset assertion, immediately: state=IDLE; cs_n/ad_n/rd_n/wr_n=1; dq_oe=0; dq_o=0; rsp_valid=0; rsp_rdata=0; all rf entries=0; timer=0; pending=0; burst index=0; busy=0.
REQ-021 Reset mid-transaction SHALL abort that transaction with no rsp_valid.

Structure
REQ-022 Package rtc_bus_pkg SHALL hold the state enum and the strobe-pattern constants per state.
REQ-023 One sub-module, rtc_phase_counter, SHALL count PHASE_CYC cycles and raise a phase-done signal; the refresh timer is a second instance of it with length REFRESH_DIV.

Verification (PHASE_CYC=2, N_REGS=3, REFRESH_DIV=100, REF_BASE=8'h21)
REQ-024 Write 0x22<-0x10 accepted at T -> dq_o=0x22 with ad_n=0 at T+1..T+2; wr_n=0 with dq_o=0x10 at T+5..T+6; rsp_valid at T+9 only.
REQ-025 Read 0x23, bus model drives 0x59 -> rd_n=0 at T+5..T+6; rsp_rdata=0x59 with rsp_valid at T+9.
REQ-026 refresh_en=1, model returns 0x11/0x22/0x33 -> after the tick, reads of 0x21, 0x22, 0x23; rf[0..2]=0x11/0x22/0x33; no rsp_valid.
REQ-027 Host request in the same cycle as the refresh tick -> host transaction runs first, then the 3-read burst; busy stays high throughout.
REQ-028 Reset asserted during DATA write -> strobes=1 and dq_oe=0 before the next edge; no rsp_valid; rf cleared; rf_addr=3 reads 0.
